// File: rtl/fetch_sequencer.sv
// IF-stage control sequencer: arbitrates branch/jump/load-use/debug-halt into PC_src, stall, flush and bubble.
// Optional perf counters (stall_cycles, redirect_count) are built when FETCH_SEQ_PERF_EN is defined.
module fetch_sequencer #(
  parameter int RESET_HOLD_CYCLES = 2,
  parameter int CNT_WIDTH         = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_branch_taken,
  input  logic       i_jump_req,
  input  logic       i_load_use_hazard,
  input  logic       i_ext_halt,
  output logic [1:0] o_PC_src,
  output logic       o_stall,
  output logic       o_flush_ifid,
  output logic       o_flush_idex,
  output logic       o_bubble_idex,
  output logic       o_halted
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] o_stall_cycles,
  output logic [CNT_WIDTH-1:0] o_redirect_count
`endif
);

  localparam int HW = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((RESET_HOLD_CYCLES > 0) ? RESET_HOLD_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_HALT
  } state_t;

  state_t          r_state;
  logic [HW-1:0]   r_hold_cnt;

  logic w_in_hold;
  logic w_in_halt;
  logic w_redirect;

  // With no hold configured, the HOLD state simply behaves as RUN.
  assign w_in_hold = (r_state == S_HOLD) && (RESET_HOLD_CYCLES != 0);
  assign w_in_halt = (r_state == S_HALT);
  assign o_halted  = w_in_halt;

  always_comb begin
    o_PC_src      = 2'b00;
    o_stall       = 1'b0;
    o_flush_ifid  = 1'b0;
    o_flush_idex  = 1'b0;
    o_bubble_idex = 1'b0;
    w_redirect    = 1'b0;
    if (i_reset || w_in_hold) begin
      o_stall       = 1'b1;
      o_bubble_idex = 1'b1;
    end else if (w_in_halt) begin
      if (i_branch_taken) begin
        o_PC_src     = 2'b01;
        o_flush_ifid = 1'b1;
        o_flush_idex = 1'b1;
        w_redirect   = 1'b1;
      end else begin
        o_stall       = 1'b1;
        o_bubble_idex = 1'b1;
      end
    end else begin
      if (i_branch_taken) begin
        o_PC_src     = 2'b01;
        o_flush_ifid = 1'b1;
        o_flush_idex = 1'b1;
        w_redirect   = 1'b1;
      end else if (i_load_use_hazard) begin
        o_stall       = 1'b1;
        o_bubble_idex = 1'b1;
      end else if (i_jump_req) begin
        o_PC_src     = 2'b10;
        o_flush_ifid = 1'b1;
        w_redirect   = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_HOLD;
      r_hold_cnt <= '0;
    end else if (w_in_hold) begin
      r_hold_cnt <= r_hold_cnt + HW'(1);
      if (r_hold_cnt == HOLD_LAST) r_state <= S_RUN;
    end else if (w_in_halt) begin
      if (!i_ext_halt) r_state <= S_RUN;
    end else begin
      // A redirect in flight finishes before halt is honoured.
      r_state <= (i_ext_halt && !w_redirect) ? S_HALT : S_RUN;
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  logic w_count_en;
  assign w_count_en = !i_reset && !w_in_hold;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_stall_cycles   <= '0;
      o_redirect_count <= '0;
    end else if (w_count_en) begin
      if (o_stall && (o_stall_cycles != {CNT_WIDTH{1'b1}}))
        o_stall_cycles <= o_stall_cycles + CNT_WIDTH'(1);
      if ((o_PC_src != 2'b00) && (o_redirect_count != {CNT_WIDTH{1'b1}}))
        o_redirect_count <= o_redirect_count + CNT_WIDTH'(1);
    end
  end
`endif

endmodule
